mem_stage: RTL and testbench

Memory-access pipeline stage between EX/MEM and the write-back stage. Issues loads and stores to the data-memory bus via a req/gnt/rvalid handshake and tolerates any number of wait states. Formats load data (sign/zero extension) and store data (byte lanes). Registers the result into the MEM/WB pipeline register (`pipeline_pkg::memwb_t`), stalling the front of the pipeline while an access is outstanding.

---
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/gnt/rvalid bus,
// formats byte lanes and registers the MEM/WB entry.
// Ports: clk/reset, EX/MEM inputs (*M), dmem_* bus, StallM, misaligned,
// outputs (pipeline_pkg::memwb_t).
package pipeline_pkg;
  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] load_data;
    logic [31:0] PCPlus4;
    logic [31:0] ImmExt;
    logic [1:0]  ResultSrc;
    logic [4:0]  Rd;
    logic        RegWrite;
  } memwb_t;
endpackage

import pipeline_pkg::*;

module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ImmExtM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        misaligned,
  output memwb_t      outputs
);

  typedef enum logic [1:0] {
    IDLE, WAIT_GNT, WAIT_RDATA
  } state_t;

  state_t      state, next;
  logic        memop, misal, req, done;
  logic [1:0]  off;
  logic [31:0] lane, ldata;

  assign off   = ALUResultM[1:0];
  assign memop = ValidM & (MemReadM | MemWriteM);

  always_comb begin
    misal   = 1'b0;
    dmem_be = 4'b1111;
    unique case (1'b1)
      funct3M[1:0] == 2'b00: dmem_be = 4'b0001 << off;
      funct3M[1:0] == 2'b01: begin
        dmem_be = 4'b0011 << off;
        misal   = off[0];
      end
      funct3M[1:0] == 2'b10: misal = |off;
      default: ;
    endcase
  end

  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_wdata = WriteDataM << {off, 3'b000};

  assign lane = dmem_rdata >> {off, 3'b000};

  always_comb begin
    ldata = '0;
    unique case (1'b1)
      funct3M == 3'b000: ldata = {{24{lane[7]}}, lane[7:0]};
      funct3M == 3'b001: ldata = {{16{lane[15]}}, lane[15:0]};
      funct3M == 3'b010: ldata = dmem_rdata;
      funct3M == 3'b100: ldata = {24'b0, lane[7:0]};
      funct3M == 3'b101: ldata = {16'b0, lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    next = state;
    req  = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        if (!memop || misal) begin
          done = 1'b1;
        end else begin
          req = 1'b1;
          if (!dmem_gnt)      next = WAIT_GNT;
          else if (MemWriteM) done = 1'b1;
          else                next = WAIT_RDATA;
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (dmem_gnt) begin
          if (MemWriteM) begin
            done = 1'b1;
            next = IDLE;
          end else begin
            next = WAIT_RDATA;
          end
        end
      end
      WAIT_RDATA: begin
        if (dmem_rvalid) begin
          done = 1'b1;
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  assign dmem_req = req & ~reset;
  assign StallM   = ~done & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      misaligned <= 1'b0;
      outputs    <= '0;
    end else begin
      state      <= next;
      misaligned <= (state == IDLE) & memop & misal;
      if (!done) begin
        outputs <= '0;
      end else begin
        outputs.ALUResult <= ALUResultM;
        outputs.load_data <=
          (state == WAIT_RDATA) ? ldata : 32'd0;
        outputs.PCPlus4   <= PCPlus4M;
        outputs.ImmExt    <= ImmExtM;
        outputs.ResultSrc <= ResultSrcM;
        outputs.Rd        <= RdM;
        outputs.RegWrite  <=
          RegWriteM & ValidM & ~(memop & misal);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed memory/ALU ops with
// a transaction-level model of bus, stall and MEM/WB behaviour.
module tb_mem_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ImmExtM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        StallM, misaligned;
  memwb_t      outputs;

  mem_stage dut (
    .clk(clk), .reset(reset), .ValidM(ValidM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .ImmExtM(ImmExtM), .ResultSrcM(ResultSrcM),
    .RdM(RdM), .RegWriteM(RegWriteM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .misaligned(misaligned),
    .outputs(outputs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model expectations for the current cycle
  bit          chk_on = 0;
  bit          e_req, e_stall, e_we;
  logic [31:0] e_addr, e_wdata, e_wmask;
  logic [3:0]  e_be;
  memwb_t      e_wb;
  bit          e_full, e_ld, e_mis;
  // expectations for the registered outputs now visible
  memwb_t      h_wb = '0;
  bit          h_full = 0, h_ld = 0, h_mis = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("misaligned", 32'(misaligned), 32'(h_mis));
      chk("wb.RegWrite", 32'(outputs.RegWrite),
          32'(h_wb.RegWrite));
      if (h_full) begin
        chk("wb.ALUResult", outputs.ALUResult, h_wb.ALUResult);
        chk("wb.PCPlus4", outputs.PCPlus4, h_wb.PCPlus4);
        chk("wb.ImmExt", outputs.ImmExt, h_wb.ImmExt);
        chk("wb.ResultSrc", 32'(outputs.ResultSrc),
            32'(h_wb.ResultSrc));
        chk("wb.Rd", 32'(outputs.Rd), 32'(h_wb.Rd));
      end
      if (h_ld)
        chk("wb.load_data", outputs.load_data, h_wb.load_data);
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      chk("StallM", 32'(StallM), 32'(e_stall));
      if (e_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_be", 32'(dmem_be), 32'(e_be));
        if (e_we)
          chk("dmem_wdata", dmem_wdata & e_wmask, e_wdata);
      end
    end
    h_wb   = e_wb;
    h_full = e_full;
    h_ld   = e_ld;
    h_mis  = e_mis;
  end

  function automatic logic [31:0] ld_model(
    input logic [2:0] f3, input logic [31:0] rd,
    input logic [1:0] off);
    logic [31:0] ln, b, h;
    ln = rd >> (8 * off);
    b  = ln & 32'hFF;
    h  = ln & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b010:  return rd;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_idle_exp();
    e_req = 0; e_stall = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_wmask = '0; e_be = '0;
    e_wb = '0; e_full = 0; e_ld = 0; e_mis = 0;
  endtask

  task automatic idle_inputs();
    ValidM = 0; MemReadM = 0; MemWriteM = 0; funct3M = 0;
    ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; ImmExtM = 0;
    ResultSrcM = 0; RdM = 0; RegWriteM = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      idle_inputs();
      set_idle_exp();
      @(posedge clk); #1;
    end
  endtask

  // one instruction; gd = cycles before gnt, rvd = gnt->rvalid gap
  task automatic run_op(input bit rd, input bit wr,
                        input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input int gd, input int rvd,
                        input logic [31:0] rdat,
                        input logic [4:0] rdn, input bit rw);
    bit memop, mis;
    int n;
    logic [1:0] off;
    logic [3:0] be;
    logic [31:0] mask;
    memwb_t ent;
    memop = rd | wr;
    off   = addr[1:0];
    mis   = memop && ((f3[1:0] == 2'b01 && addr[0]) ||
                      (f3[1:0] == 2'b10 && addr[1:0] != 0));
    if (!memop || mis) n = 1;
    else if (wr)       n = gd + 1;
    else               n = gd + rvd + 1;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    mask = '0;
    for (int i = 0; i < 4; i++)
      if (be[i]) mask[8*i +: 8] = 8'hFF;
    ent.ALUResult = addr;
    ent.load_data = ld_model(f3, rdat, off);
    ent.PCPlus4   = addr + 4;
    ent.ImmExt    = ~addr;
    ent.ResultSrc = {1'b0, rd};
    ent.Rd        = rdn;
    ent.RegWrite  = rw && !mis;
    for (int c = 0; c < n; c++) begin
      ValidM = 1; MemReadM = rd; MemWriteM = wr; funct3M = f3;
      ALUResultM = addr; WriteDataM = wd;
      PCPlus4M = ent.PCPlus4; ImmExtM = ent.ImmExt;
      ResultSrcM = ent.ResultSrc; RdM = rdn; RegWriteM = rw;
      dmem_gnt = memop && !mis && c == gd;
      dmem_rvalid = rd && !mis && (c == gd + rvd || c < gd);
      dmem_rdata = (c == gd + rvd) ? rdat : 32'hDEADBEEF;
      e_req   = memop && !mis && c <= gd;
      e_stall = c < n - 1;
      e_we    = wr;
      e_addr  = {addr[31:2], 2'b00};
      e_be    = be;
      e_wmask = mask;
      e_wdata = (wd << (8 * off)) & mask;
      if (c == n - 1) begin
        e_wb = ent; e_full = 1; e_ld = rd && !mis;
        e_mis = mis;
      end else begin
        e_wb = '0; e_full = 0; e_ld = 0; e_mis = 0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    set_idle_exp();
    reset = 1;
    ValidM = 1; MemReadM = 1; ALUResultM = 32'h200;
    funct3M = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst StallM", 32'(StallM), 32'd0);
    chk("rst misaligned", 32'(misaligned), 32'd0);
    chk("rst outputs lo", outputs[31:0], 32'd0);
    chk("rst outputs.RegWrite", 32'(outputs.RegWrite), 32'd0);
    chk("rst outputs.ALUResult", outputs.ALUResult, 32'd0);
    idle_inputs();
    reset = 0;
    chk_on = 1;
    idle(1);

    // non-memory instruction
    run_op(0, 0, 3'b000, 32'h1234, 0, 0, 0, 0, 5'd5, 1);
    chk("lit nonmem ALUResult", outputs.ALUResult, 32'h1234);
    chk("lit nonmem Rd", 32'(outputs.Rd), 32'd5);
    chk("lit nonmem RegWrite", 32'(outputs.RegWrite), 32'd1);

    // SB, zero wait: pinned literally, then through the model
    chk_on = 0;
    ValidM = 1; MemWriteM = 1; funct3M = 3'b000;
    ALUResultM = 32'h103; WriteDataM = 32'hAB; dmem_gnt = 1;
    RegWriteM = 0;
    #2;
    chk("lit SB be", 32'(dmem_be), 32'h8);
    chk("lit SB wdata", 32'(dmem_wdata[31:24]), 32'hAB);
    chk("lit SB req", 32'(dmem_req), 32'd1);
    chk("lit SB StallM", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    idle(1);
    chk_on = 1;
    run_op(0, 1, 3'b000, 32'h103, 32'hAB, 0, 0, 0, 5'd0, 0);

    // SW with 3-cycle grant delay
    run_op(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 3, 0, 0, 5'd0, 0);
    // SH upper half, 1 wait
    run_op(0, 1, 3'b001, 32'h102, 32'h1234, 1, 0, 0, 5'd0, 0);

    // LB / LBU at 0x202, rvalid 2 cycles after gnt
    run_op(1, 0, 3'b000, 32'h202, 0, 0, 2, 32'h00800000, 5'd7, 1);
    chk("lit LB load_data", outputs.load_data, 32'hFFFFFF80);
    run_op(1, 0, 3'b100, 32'h202, 0, 0, 2, 32'h00800000, 5'd8, 1);
    chk("lit LBU load_data", outputs.load_data, 32'h00000080);

    // LH / LHU / LW with grant waits, back-to-back
    run_op(1, 0, 3'b001, 32'h402, 0, 2, 1, 32'h80017F00, 5'd9, 1);
    chk("lit LH load_data", outputs.load_data, 32'hFFFF8001);
    run_op(1, 0, 3'b101, 32'h402, 0, 0, 1, 32'h80017F00, 5'd10, 1);
    run_op(1, 0, 3'b010, 32'h500, 0, 1, 3, 32'h13579BDF, 5'd11, 1);
    run_op(1, 0, 3'b000, 32'h501, 0, 0, 1, 32'h00007F00, 5'd12, 1);

    // misaligned LW and SH
    run_op(1, 0, 3'b010, 32'h101, 0, 0, 1, 0, 5'd13, 1);
    chk("lit mis pulse", 32'(misaligned), 32'd1);
    chk("lit mis RegWrite", 32'(outputs.RegWrite), 32'd0);
    run_op(0, 1, 3'b001, 32'h103, 32'h5555, 0, 0, 0, 5'd0, 0);
    run_op(0, 0, 3'b000, 32'h77, 0, 0, 0, 0, 5'd3, 1);
    idle(2);

    // reset while waiting for read data; late rvalid ignored
    chk_on = 0;
    ValidM = 1; MemReadM = 1; funct3M = 3'b010;
    ALUResultM = 32'h200; RegWriteM = 1; RdM = 5'd4;
    dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0;
    chk("lit WAIT_RDATA StallM", 32'(StallM), 32'd1);
    reset = 1;
    #1;
    chk("mid-rst dmem_req", 32'(dmem_req), 32'd0);
    chk("mid-rst StallM", 32'(StallM), 32'd0);
    chk("mid-rst outputs", outputs[31:0], 32'd0);
    chk("mid-rst misaligned", 32'(misaligned), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    dmem_rvalid = 1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("post-rst StallM", 32'(StallM), 32'd0);
    chk("post-rst dmem_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    chk("post-rst RegWrite", 32'(outputs.RegWrite), 32'd0);
    chk("post-rst load_data", outputs.load_data, 32'd0);
    chk("post-rst ALUResult", outputs.ALUResult, 32'd0);
    idle(1);
    chk_on = 1;
    run_op(1, 0, 3'b010, 32'h600, 0, 0, 1, 32'h24681357, 5'd6, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
